// File: rtl/simple_vending_machine.sv
// Coin-accepting controller for one 15-unit product: accepts 5- and 10-unit coins
// and pulses dispense once accumulated credit reaches 15. Overpayment is forfeited.
module simple_vending_machine (
  input  logic clk,
  input  logic rst,
  input  logic coin5,
  input  logic coin10,
  output logic dispense
);

  localparam logic [1:0] S0  = 2'b00;
  localparam logic [1:0] S5  = 2'b01;
  localparam logic [1:0] S10 = 2'b10;

  logic [1:0] r_state;
  logic       r_dispense;
  logic [1:0] w_nextState;
  logic       w_nextDispense;

  // Both coins on one edge are worth 15, which completes a purchase from any credit.
  always_comb begin
    w_nextState    = r_state;
    w_nextDispense = 1'b0;
    unique case (r_state)
      S0: begin
        if (coin5 && coin10) begin
          w_nextState    = S0;
          w_nextDispense = 1'b1;
        end else if (coin10) begin
          w_nextState = S10;
        end else if (coin5) begin
          w_nextState = S5;
        end
      end
      S5: begin
        if (coin10) begin
          w_nextState    = S0;
          w_nextDispense = 1'b1;
        end else if (coin5) begin
          w_nextState = S10;
        end
      end
      S10: begin
        if (coin5 || coin10) begin
          w_nextState    = S0;
          w_nextDispense = 1'b1;
        end
      end
      default: begin
        w_nextState    = S0;
        w_nextDispense = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S0;
      r_dispense <= 1'b0;
    end else begin
      r_state    <= w_nextState;
      r_dispense <= w_nextDispense;
    end
  end

  assign dispense = r_dispense;

endmodule

// File: tb/tb_simple_vending_machine.sv
// Scoreboard bench for simple_vending_machine: a credit-counting reference model
// queues expected credit/dispense per edge and a monitor compares after each edge.
module tb_simple_vending_machine;

  logic clk;
  logic rst;
  logic coin5;
  logic coin10;
  logic dispense;

  typedef struct {
    logic [1:0] st;
    logic       disp;
    string      tag;
  } exp_t;

  exp_t expQ[$];
  int   checks;
  int   failures;
  int   credit;

  simple_vending_machine dut (
    .clk      (clk),
    .rst      (rst),
    .coin5    (coin5),
    .coin10   (coin10),
    .dispense (dispense)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [1:0] actSt, input logic actDisp,
                             input logic [1:0] expSt, input logic expDisp);
    checks++;
    if (actSt !== expSt || actDisp !== expDisp) begin
      failures++;
      $display("[TB] FAIL %s: got state=%b dispense=%b, expected state=%b dispense=%b",
               name, actSt, actDisp, expSt, expDisp);
    end
  endtask

  // Reference model: credit in units, a purchase completes at 15 or more.
  task automatic applyStimulus(input bit c5, input bit c10, input bit r, input string tag);
    exp_t e;
    @(negedge clk);
    coin5  = c5;
    coin10 = c10;
    rst    = r;
    e.disp = 1'b0;
    if (!r) begin
      credit = 0;
    end else begin
      credit += (c5 ? 5 : 0) + (c10 ? 10 : 0);
      if (credit >= 15) begin
        credit = 0;
        e.disp = 1'b1;
      end
    end
    e.st  = 2'(credit / 5);
    e.tag = tag;
    expQ.push_back(e);
  endtask

  // Pull reset low mid-cycle and confirm it acts before the next edge.
  task automatic asyncResetCheck(input string tag);
    exp_t e;
    @(negedge clk);
    coin5  = 1'b0;
    coin10 = 1'b0;
    #2 rst = 1'b0;
    #1 checkOutput({tag, "_async"}, dut.r_state, dispense, 2'b00, 1'b0);
    credit = 0;
    e.st   = 2'b00;
    e.disp = 1'b0;
    e.tag  = {tag, "_held"};
    expQ.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        checkOutput(e.tag, dut.r_state, dispense, e.st, e.disp);
      end
    end
  end

  initial begin : stimulus
    int waitCycles;
    bit c5;
    bit c10;
    checks   = 0;
    failures = 0;
    credit   = 0;
    rst      = 1'b0;
    coin5    = 1'b0;
    coin10   = 1'b0;
    #1 checkOutput("reset_initial", dut.r_state, dispense, 2'b00, 1'b0);

    applyStimulus(1, 0, 0, "reset_hold_c5");
    applyStimulus(0, 1, 0, "reset_hold_c10");
    applyStimulus(1, 1, 0, "reset_hold_both");

    applyStimulus(0, 0, 1, "idle_after_reset");
    applyStimulus(1, 0, 1, "c5_to_s5");
    applyStimulus(0, 1, 1, "s5_c10_dispense");
    applyStimulus(1, 0, 1, "c5_again");
    applyStimulus(0, 0, 1, "hold_s5");
    applyStimulus(1, 0, 1, "s5_c5_to_s10");
    applyStimulus(0, 0, 1, "hold_s10");
    applyStimulus(1, 0, 1, "s10_c5_dispense");
    applyStimulus(1, 0, 1, "three_c5_a");
    applyStimulus(1, 0, 1, "three_c5_b");
    applyStimulus(1, 0, 1, "three_c5_c");
    applyStimulus(0, 1, 1, "c10_to_s10");
    applyStimulus(0, 1, 1, "s10_c10_overpay");
    applyStimulus(1, 1, 1, "s0_both_dispense");
    applyStimulus(1, 1, 1, "back_to_back_both");
    applyStimulus(1, 0, 1, "c5_before_both");
    applyStimulus(1, 1, 1, "s5_both_dispense");
    applyStimulus(0, 1, 1, "c10_before_both");
    applyStimulus(1, 1, 1, "s10_both_dispense");
    applyStimulus(0, 0, 1, "idle_after_both");

    applyStimulus(0, 1, 1, "to_s10_for_reset");
    asyncResetCheck("reset_in_s10");
    applyStimulus(0, 0, 1, "release_after_s10");
    applyStimulus(1, 1, 1, "dispense_for_reset");
    asyncResetCheck("reset_during_dispense");
    applyStimulus(0, 0, 1, "release_after_dispense");

    for (int i = 0; i < 300; i++) begin
      c5  = ($urandom_range(0, 2) == 0);
      c10 = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 49) == 0)
        applyStimulus(c5, c10, 0, "random_reset");
      else
        applyStimulus(c5, c10, 1, "random");
    end
    applyStimulus(0, 0, 1, "final_idle");

    waitCycles = 0;
    while (expQ.size() > 0 && waitCycles < 10) begin
      @(posedge clk);
      waitCycles++;
    end
    #2;
    if (expQ.size() > 0) begin
      checks++;
      failures++;
      $display("[TB] FAIL drain: %0d entries left, expected 0", expQ.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
